// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: access-size encodings, FSM states and
// the load lane-select/extension helper.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    // Half needs addr[0]=0, word (11 and the alias 10) needs addr[1:0]=0.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] low);
        unique case (size)
            SIZE_BYTE: return 1'b1;
            SIZE_HALF: return ~low[0];
            default:   return (low == 2'b00);
        endcase
    endfunction

    // Little-endian lane select followed by sign or zero extension.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size,
                                                input logic        is_unsigned);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        unique case (size)
            SIZE_BYTE: return is_unsigned ? {24'd0, b} : {{24{b[7]}}, b};
            SIZE_HALF: return is_unsigned ? {16'd0, h} : {{16{h[15]}}, h};
            default:   return word;
        endcase
    endfunction

endpackage

// File: rtl/memory_data_be.sv
// Word-wide data memory with per-byte write enables, synchronous clear on
// reset, one synchronous functional read port and one debug read port.
module memory_data_be #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage, byte-lane writes and both registered read ports.
    // Reads use pre-write contents, so a same-cycle store shows old data.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata     <= '0;
            dbg_rdata <= '0;
        end else begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end
            rdata     <= mem[raddr];
            dbg_rdata <= mem[dbg_addr];
        end
    end

endmodule

// File: rtl/mem_stage_multicycle.sv
// MIPS MEM stage: multi-cycle byte/half/word load/store FSM with pipeline
// stall handshake, misalignment rejection and a registered debug read port.
// Optional MEM_ACCESS_COUNT_EN adds saturating load/store completion counters.
module mem_stage_multicycle
    import mem_pkg::*;
#(
    parameter int unsigned BITS_SIZE     = 32,
    parameter int unsigned SIZE_MEM_DATA = 10,
    parameter int unsigned MEM_LATENCY   = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_step,
    input  logic [BITS_SIZE-1:0] i_exmem_alu,
    input  logic [BITS_SIZE-1:0] i_exmem_mem_register2,
    input  logic                 i_exmem_mem_read,
    input  logic                 i_exmem_mem_write,
    input  logic [1:0]           i_ctl_datomem_size,
    input  logic                 i_ctl_unsigned,
    input  logic [BITS_SIZE-1:0] i_addr_mem_debug,
    output logic [BITS_SIZE-1:0] o_mem_dato,
    output logic                 o_done,
    output logic                 o_stall,
    output logic                 o_misaligned,
    output logic [BITS_SIZE-1:0] o_mem_dato_debug
`ifdef MEM_ACCESS_COUNT_EN
    ,
    output logic [BITS_SIZE-1:0] o_load_count,
    output logic [BITS_SIZE-1:0] o_store_count
`endif
);

    localparam int unsigned ADDR_LO_W = SIZE_MEM_DATA + 2;

    state_e                 state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [ADDR_LO_W-1:0]   addr_q;
    logic [BITS_SIZE-1:0]   data_q;
    logic [1:0]             size_q;
    logic                   uns_q;
    logic                   wr_q;
    logic                   done_q;
    logic                   mis_q;
    logic [BITS_SIZE-1:0]   dato_q;

    logic                   req;
    logic                   aligned;
    logic                   accept;
    logic                   mis_req;
    logic                   we;
    logic [3:0]             be;
    logic [BITS_SIZE-1:0]   wdata;
    logic [BITS_SIZE-1:0]   rdata;
    logic [SIZE_MEM_DATA-1:0] rd_idx;

    // Upper address bits wrap modulo depth; debug byte offset is ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_exmem_alu[BITS_SIZE-1:ADDR_LO_W],
                                i_addr_mem_debug[BITS_SIZE-1:ADDR_LO_W],
                                i_addr_mem_debug[1:0]};

    assign req     = i_exmem_mem_read | i_exmem_mem_write;
    assign aligned = is_aligned(i_ctl_datomem_size, i_exmem_alu[1:0]);

    // Next-state, counter and stall/accept decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        mis_req = 1'b0;
        o_stall = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_step && req) begin
                    if (aligned) begin
                        accept  = 1'b1;
                        o_stall = 1'b1;
                        cnt_d   = 3'(MEM_LATENCY - 1);
                        state_d = (MEM_LATENCY == 1) ? StDone : StBusy;
                    end else begin
                        mis_req = 1'b1;
                    end
                end
            end
            StBusy: begin
                o_stall = 1'b1;
                if (i_step) begin
                    if (cnt_q <= 3'd1) begin
                        cnt_d   = '0;
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end
            StDone: begin
                if (i_step) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Read the incoming address while idle so data is ready by the DONE cycle.
    assign rd_idx = (state_q == StIdle) ? i_exmem_alu[ADDR_LO_W-1:2] : addr_q[ADDR_LO_W-1:2];

    // Store formatting: replicate the datum and enable only the target lanes.
    always_comb begin
        we    = (state_q == StDone) && i_step && wr_q;
        be    = 4'b1111;
        wdata = data_q;
        unique case (size_q)
            SIZE_BYTE: begin
                be    = 4'b0001 << addr_q[1:0];
                wdata = {4{data_q[7:0]}};
            end
            SIZE_HALF: begin
                be    = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata = {2{data_q[15:0]}};
            end
            default: ;
        endcase
    end

    // FSM state, request latch and registered outputs; everything holds while i_step=0.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            size_q  <= SIZE_BYTE;
            uns_q   <= 1'b0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            dato_q  <= '0;
        end else if (i_step) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= (state_q == StDone);
            mis_q   <= mis_req;
            if (accept) begin
                addr_q <= i_exmem_alu[ADDR_LO_W-1:0];
                data_q <= i_exmem_mem_register2;
                size_q <= i_ctl_datomem_size;
                uns_q  <= i_ctl_unsigned;
                wr_q   <= i_exmem_mem_write;
            end
            if (state_q == StDone && !wr_q) begin
                dato_q <= BITS_SIZE'(load_extend(rdata, addr_q[1:0], size_q, uns_q));
            end
        end
    end

    assign o_mem_dato   = dato_q;
    assign o_done       = done_q;
    assign o_misaligned = mis_q;

    memory_data_be #(
        .DATA_W (BITS_SIZE),
        .ADDR_W (SIZE_MEM_DATA)
    ) u_mem (
        .clk       (i_clk),
        .reset     (i_reset),
        .we        (we),
        .be        (be),
        .waddr     (addr_q[ADDR_LO_W-1:2]),
        .wdata     (wdata),
        .raddr     (rd_idx),
        .rdata     (rdata),
        .dbg_addr  (i_addr_mem_debug[ADDR_LO_W-1:2]),
        .dbg_rdata (o_mem_dato_debug)
    );

`ifdef MEM_ACCESS_COUNT_EN
    logic [BITS_SIZE-1:0] load_cnt_q;
    logic [BITS_SIZE-1:0] store_cnt_q;

    // Saturating completion counters, bumped in the DONE cycle of each op type.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
        end else if (i_step && state_q == StDone) begin
            if (wr_q && !(&store_cnt_q)) begin
                store_cnt_q <= store_cnt_q + 1'b1;
            end
            if (!wr_q && !(&load_cnt_q)) begin
                load_cnt_q <= load_cnt_q + 1'b1;
            end
        end
    end

    assign o_load_count  = load_cnt_q;
    assign o_store_count = store_cnt_q;
`else
    // Access counters compiled out.
`endif

endmodule

// File: doc/mem_stage_multicycle.md
Name: mem_stage_multicycle

Overview:
- Next-generation MIPS MEM stage.
- Wraps a parametrised byte-addressable data memory behind a multi-cycle access FSM with a stall handshake to the pipeline.
- Supports byte/half/word loads and stores with sign/zero extension, misalignment detection, and a registered debug read port.
- Sits between the EX/MEM and MEM/WB registers; `o_stall` freezes upstream stages while an access is in flight.

Parameters:
- BITS_SIZE, 32: data and address width.
- SIZE_MEM_DATA, 10: log2 of memory depth in words (1024 words).
- MEM_LATENCY, 2: cycles from request acceptance to result; legal range 1..4.

Ports:
- i_clk  in  1  single clock, all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_step  in  1  advance enable (debug step mode); when low, all state holds.
- i_exmem_alu  in  BITS_SIZE  byte address.
- i_exmem_mem_register2  in  BITS_SIZE  store data.
- i_exmem_mem_read  in  1  load request.
- i_exmem_mem_write  in  1  store request.
- i_ctl_datomem_size  in  2  00 byte, 01 half, 11 word, 10 treated as word.
- i_ctl_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend.
- i_addr_mem_debug  in  BITS_SIZE  debug word address (byte address, bits [1:0] ignored).
- o_mem_dato  out  BITS_SIZE  load result, held until the next load completes.
- o_done  out  1  one-cycle pulse when an access completes.
- o_stall  out  1  pipeline stall request.
- o_misaligned  out  1  one-cycle pulse on a rejected misaligned request.
- o_mem_dato_debug  out  BITS_SIZE  registered debug read data.

Behaviour:
- Reset: state IDLE, memory cleared to 0, and all outputs 0.
- States: IDLE, BUSY, DONE. Nothing advances while i_step=0, including the latency counter and memory writes.
- IDLE, with i_step=1 and (read|write):
  - Latch address, data, size, unsigned flag, and op.
  - Load counter with MEM_LATENCY-1; go to BUSY.
  - If MEM_LATENCY=1, go directly to DONE.
  - If read and write are both set, write wins.
- BUSY: decrement counter; at 0 go to DONE.
- DONE:
  - Store: write with byte enables.
  - Load: extract the lane, extend it, and register it into o_mem_dato.
  - Pulse o_done; return to IDLE.
- Latency: a request accepted at edge T produces o_done and valid o_mem_dato at edge T+MEM_LATENCY. Stores are visible to loads accepted after o_done.
- o_stall is combinational: (IDLE & i_step & req & aligned) | BUSY. It is low in the DONE cycle so the pipeline advances with the result.
- Alignment:
  - half requires addr[0]=0; word requires addr[1:0]=0.
  - A violation in IDLE pulses o_misaligned and performs no access and no stall.
  - o_mem_dato is unchanged.
- Byte lanes are little-endian: lane = addr[1:0], halfword = addr[1].
  - Byte store replicates data[7:0] into the addressed lane only.
  - Half store writes 2 lanes.
- Address range: word index = addr[SIZE_MEM_DATA+1:2]; upper address bits are ignored, so accesses wrap modulo depth.
- Debug port:
  - o_mem_dato_debug <= mem[debug index] every cycle, independent of i_step.
  - A same-cycle store shows the old data.
- Reset mid-access aborts the access: no write occurs, and o_stall drops at the next edge.

Optional Feature:
- MEM_ACCESS_COUNT_EN defined:
  - Adds outputs o_load_count and o_store_count, both BITS_SIZE wide.
  - Each increments in the DONE cycle of its op type and saturates at all-ones.
  - Both are cleared by reset; misaligned requests are not counted.
- MEM_ACCESS_COUNT_EN undefined: the ports and counters do not exist.

Decomposition:
- Shared package `mem_pkg` holds:
  - Size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD).
  - FSM state enum.
  - Load-extension function (lane select + sign/zero extend).
- One sub-module, `memory_data_be`: word-wide array with 4-bit byte-enable write, synchronous reset clear, one synchronous functional read port, and one debug read port.

Test Plan:
- MEM_LATENCY=2: store word 0xDEADBEEF to 0x10, then load word from 0x10.
  - o_done exactly 2 cycles after acceptance.
  - o_mem_dato=0xDEADBEEF.
  - o_stall high for 2 cycles per access.
- Load byte from 0x13 (i_ctl_unsigned=0) → 0xFFFFFFDE. Load byte unsigned → 0x000000DE. Load half from 0x12 signed → 0xFFFFDEAD.
- Store byte 0x55 to 0x11, then read word 0x10 → 0xDEAD55EF. Debug read of 0x10 one cycle later shows the same value.
- Load half from 0x11 → o_misaligned pulses for 1 cycle, o_stall=0, no o_done, o_mem_dato unchanged.
- Hold i_step=0 for 5 cycles mid-BUSY → state and o_stall frozen; completion is delayed by exactly 5 cycles.
- Assert i_reset during BUSY of a store to 0x20 → o_stall=0 next cycle; a later load from 0x20 returns 0.
